// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM state
// encoding and the per-opcode datapath latency.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NAND = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_INC  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIV  = 4'd9;
    localparam logic [3:0] OP_EQ   = 4'd10;
    localparam logic [3:0] OP_GE   = 4'd11;
    localparam logic [3:0] OP_LE   = 4'd12;
    localparam logic [3:0] OP_GT   = 4'd13;
    localparam logic [3:0] OP_LT   = 4'd14;
    localparam logic [3:0] OP_RSVD = 4'd15;

    // Code 2'b11 is unused and steers back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } seq_state_t;

    // Number of EXEC cycles the datapath needs before its result is valid.
    function automatic logic [3:0] op_latency(input logic [3:0] op,
                                              input int mul_cycles,
                                              input int div_cycles);
        logic [3:0] n;
        n = 4'd1;
        if (op == OP_MUL) begin
            n = mul_cycles[3:0];
        end else if (op == OP_DIV) begin
            n = div_cycles[3:0];
        end
        return n;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_cycle_counter.sv
// 4-bit loadable down-counter that times the EXEC phase. It holds at zero
// instead of wrapping, and zero flags the final EXEC cycle.
module alu_cycle_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] cnt,
    output logic       zero
);

    // Load on accept, otherwise count down and stop at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer for the 8-bit ALU datapath and its 16:1 result mux.
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; a requester holds valid (and its payload) until it sees ready, and the
// sequencer holds rsp_valid and its payload until rsp_ready.
// Optional macro ALU_DIV0_TRAP_EN: DIV by zero finishes in one EXEC cycle with
// rsp_result=16'hFFFF and rsp_err=1 instead of waiting for the datapath.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic        busy
);

    seq_state_t state;
    seq_state_t next_state;
    logic       accept;
    logic       cnt_load;
    logic       capture;
    logic [3:0] lat;
    logic [3:0] cnt;
    logic       cnt_zero;
    logic       is_rsvd;
    logic       is_trap;

    assign accept = req_valid & req_ready;

    // Latency of the incoming request, with the divide-by-zero shortcut when enabled.
    always_comb begin
        lat = op_latency(req_op, MUL_CYCLES, DIV_CYCLES);
`ifdef ALU_DIV0_TRAP_EN
        if (req_op == OP_DIV && req_b == 8'd0) begin
            lat = 4'd1;
        end
`endif
    end

    // Error classification uses the latched operands, which are stable through EXEC.
    always_comb begin
        is_rsvd = (alu_op == OP_RSVD);
`ifdef ALU_DIV0_TRAP_EN
        is_trap = (alu_op == OP_DIV) && (alu_b == 8'd0);
`else
        is_trap = 1'b0;
`endif
    end

    alu_cycle_counter u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (lat - 4'd1),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the counter-load and result-capture strobes.
    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_EXEC;
                    cnt_load   = 1'b1;
                end
            end
            ST_EXEC: begin
                if (cnt_zero) begin
                    next_state = ST_DONE;
                    capture    = 1'b1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // req_ready lags entry to IDLE by one edge and drops on the accept edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
        end else begin
            req_ready <= (state == ST_IDLE) && !accept;
        end
    end

    // Operand/opcode latch to the datapath, held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op <= 4'd0;
            alu_a  <= 8'd0;
            alu_b  <= 8'd0;
        end else if (accept) begin
            alu_op <= req_op;
            alu_a  <= req_a;
            alu_b  <= req_b;
        end
    end

    // Response capture at the end of EXEC; held through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= 16'h0000;
            rsp_err    <= 1'b0;
        end else if (capture) begin
            if (is_rsvd) begin
                rsp_result <= 16'h0000;
                rsp_err    <= 1'b1;
            end else if (is_trap) begin
                rsp_result <= 16'hFFFF;
                rsp_err    <= 1'b1;
            end else begin
                rsp_result <= alu_result;
                rsp_err    <= 1'b0;
            end
        end
    end

    assign rsp_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural model of the ALU
// datapath feeding alu_result. Latencies are counted in rising edges with the
// accept edge counted as the first one.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int MUL_N = 4;
    localparam int DIV_N = 8;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic        busy;

    int checks;
    int failures;
    logic [15:0] exp_q[$];

    alu_op_sequencer #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- datapath model ----------------
    function automatic logic [15:0] dp_model(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        logic [15:0] r;
        r = 16'h0000;
        case (op)
            OP_AND:  r = {8'h00, a & b};
            OP_OR:   r = {8'h00, a | b};
            OP_XOR:  r = {8'h00, a ^ b};
            OP_NAND: r = {8'h00, ~(a & b)};
            OP_NOR:  r = {8'h00, ~(a | b)};
            OP_ADD:  r = {8'h00, a} + {8'h00, b};
            OP_SUB:  r = {8'h00, a} - {8'h00, b};
            OP_INC:  r = {8'h00, a} + 16'd1;
            OP_MUL:  r = {8'h00, a} * {8'h00, b};
            OP_DIV:  r = (b == 8'd0) ? 16'h00EE : {8'h00, a / b};
            OP_EQ:   r = {15'd0, a == b};
            OP_GE:   r = {15'd0, a >= b};
            OP_LE:   r = {15'd0, a <= b};
            OP_GT:   r = {15'd0, a > b};
            OP_LT:   r = {15'd0, a < b};
            default: r = 16'hBAD0;
        endcase
        return r;
    endfunction

    assign alu_result = dp_model(alu_op, alu_a, alu_b);

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_result"}, 32'(rsp_result), 0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 0);
        check({tag, "_alu_op"}, 32'(alu_op), 0);
        check({tag, "_alu_a"}, 32'(alu_a), 0);
        check({tag, "_alu_b"}, 32'(alu_b), 0);
    endtask

    // ---------------- drivers ----------------
    // Present a request and return once the accept edge has passed (sampled #1 after it).
    task automatic send_req(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp_res);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        guard     = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        exp_q.push_back(exp_res);
    endtask

    // Count edges (accept edge = 1) until rsp_valid; optionally check operands each EXEC cycle.
    task automatic wait_rsp(input string tag, input int exp_edges, input logic [3:0] op,
                            input logic [7:0] a, input logic [7:0] b, input bit chk_ops);
        int n;
        n = 1;
        while (!rsp_valid && n < 40) begin
            if (chk_ops) begin
                check({tag, "_alu_op_stable"}, 32'(alu_op), 32'(op));
                check({tag, "_alu_a_stable"}, 32'(alu_a), 32'(a));
                check({tag, "_alu_b_stable"}, 32'(alu_b), 32'(b));
            end
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_edges));
    endtask

    task automatic check_rsp(input string tag, input logic exp_err);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 0, 1);
            e = 16'h0000;
        end else begin
            e = exp_q.pop_front();
        end
        check({tag, "_rsp_result"}, 32'(rsp_result), 32'(e));
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
    endtask

    // Accept the response and verify the return to idle.
    task automatic take_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 0);
        check({tag, "_req_ready_lag"}, 32'(req_ready), 0);
        @(posedge clk);
        #1;
        check({tag, "_req_ready_back"}, 32'(req_ready), 1);
        check({tag, "_busy_idle"}, 32'(busy), 0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        logic [15:0] held;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_op    = OP_ADD;
        req_a     = 8'h00;
        req_b     = 8'h00;
        rsp_ready = 1'b0;

        // 1: reset with req_valid asserted
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("reset_first_edge_req_ready", 32'(req_ready), 1);
        check("reset_first_edge_busy", 32'(busy), 0);

        // 2: ADD 0x0F + 0x01
        send_req(OP_ADD, 8'h0F, 8'h01, 16'h0010);
        check("add_busy", 32'(busy), 1);
        check("add_req_ready_low", 32'(req_ready), 0);
        wait_rsp("add", 2, OP_ADD, 8'h0F, 8'h01, 1'b0);
        check_rsp("add", 1'b0);
        take_rsp("add");

        // 3: MUL 12 * 10 with operand stability through EXEC
        send_req(OP_MUL, 8'd12, 8'd10, 16'd120);
        wait_rsp("mul", MUL_N + 1, OP_MUL, 8'd12, 8'd10, 1'b1);
        check_rsp("mul", 1'b0);
        take_rsp("mul");

        // 4: backpressure on a SUB, rsp_ready asserted early has no effect
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        send_req(OP_SUB, 8'h30, 8'h05, 16'h002B);
        wait_rsp("bp", 2, OP_SUB, 8'h30, 8'h05, 1'b0);
        held = rsp_result;
        check_rsp("bp", 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("bp_rsp_valid_held", 32'(rsp_valid), 1);
            check("bp_rsp_result_held", 32'(rsp_result), 32'h002B);
            check("bp_req_ready_low", 32'(req_ready), 0);
        end
        check("bp_result_unchanged", 32'(rsp_result), 32'(held));
        take_rsp("bp");

        // 5: reserved opcode, then DIV by zero
        send_req(OP_RSVD, 8'hAA, 8'h55, 16'h0000);
        wait_rsp("rsvd", 2, OP_RSVD, 8'hAA, 8'h55, 1'b0);
        check_rsp("rsvd", 1'b1);
        take_rsp("rsvd");

`ifdef ALU_DIV0_TRAP_EN
        send_req(OP_DIV, 8'd50, 8'd0, 16'hFFFF);
        wait_rsp("div0", 2, OP_DIV, 8'd50, 8'd0, 1'b0);
        check_rsp("div0", 1'b1);
`else
        send_req(OP_DIV, 8'd50, 8'd0, 16'h00EE);
        wait_rsp("div0", DIV_N + 1, OP_DIV, 8'd50, 8'd0, 1'b0);
        check_rsp("div0", 1'b0);
`endif
        take_rsp("div0");

        // Compare op returns the datapath's 1-bit result widened
        send_req(OP_GT, 8'd9, 8'd3, 16'h0001);
        wait_rsp("gt", 2, OP_GT, 8'd9, 8'd3, 1'b0);
        check_rsp("gt", 1'b0);
        take_rsp("gt");

        // 6: reset on the 3rd EXEC cycle of a DIV
        send_req(OP_DIV, 8'd9, 8'd3, 16'h0003);
        void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        #1;
        check("midop_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midop_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DIV_N + 4; i++) begin
            @(posedge clk);
            #1;
            check("midop_no_rsp", 32'(rsp_valid), 0);
        end
        send_req(OP_ADD, 8'h21, 8'h12, 16'h0033);
        wait_rsp("post_reset_add", 2, OP_ADD, 8'h21, 8'h12, 1'b0);
        check_rsp("post_reset_add", 1'b0);
        take_rsp("post_reset_add");

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
